// File: rtl/programmable_timeout_timer_if.sv
// Control/status bundle for programmable_timeout_timer.
// master drives commands (game FSM or bench); slave is the timer itself.
interface programmable_timeout_timer_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic             start;
   logic             abort;
   logic             pause;
   logic             periodic;
   logic [CNT_W-1:0] load_ms;
   logic             busy;
   logic             timeout;
   logic             done;
   logic [CNT_W-1:0] remaining_ms;
   logic             warn;

   modport master (
      output start, abort, pause, periodic, load_ms,
      input  busy, timeout, done, remaining_ms, warn
   );

   modport slave (
      input  start, abort, pause, periodic, load_ms,
      output busy, timeout, done, remaining_ms, warn
   );
endinterface

// File: rtl/programmable_timeout_timer.sv
// Prescaled 1 ms down-counter with one-shot/periodic modes, pause, abort and restart.
// Define TIMER_WARN_EN to build the remaining-time warn pulse; otherwise warn is tied low.
module programmable_timeout_timer #(
   parameter int unsigned TICKS_PER_MS = 50000,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned WARN_MS      = 1000
) (
   input logic                         clk,
   input logic                         rst,
   programmable_timeout_timer_if.slave tmr_io
);
   localparam int unsigned   PW       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(TICKS_PER_MS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic             periodic_q, periodic_d;
   logic             timeout_q, timeout_d;
   logic             ms_tick;

   // A millisecond boundary only counts when no command overrides it this cycle.
   assign ms_tick = !tmr_io.abort && !tmr_io.start && (state_q == StRun) &&
                    !tmr_io.pause && (presc_q == PrescMax);

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      rem_d      = rem_q;
      load_d     = load_q;
      periodic_d = periodic_q;
      timeout_d  = 1'b0;

      if (tmr_io.abort) begin
         state_d = StIdle;
         presc_d = '0;
         rem_d   = '0;
      end else if (tmr_io.start) begin
         presc_d    = '0;
         load_d     = tmr_io.load_ms;
         periodic_d = tmr_io.periodic;
         if (tmr_io.load_ms != '0) begin
            rem_d   = tmr_io.load_ms;
            state_d = StRun;
         end else begin
            // Zero interval expires immediately without entering RUN.
            rem_d     = '0;
            timeout_d = 1'b1;
            state_d   = tmr_io.periodic ? StIdle : StExpired;
         end
      end else if ((state_q == StRun) && !tmr_io.pause) begin
         if (ms_tick) begin
            presc_d = '0;
            if (rem_q <= CNT_W'(1)) begin
               timeout_d = 1'b1;
               if (periodic_q) begin
                  rem_d = load_q;
               end else begin
                  rem_d   = '0;
                  state_d = StExpired;
               end
            end else begin
               rem_d = rem_q - CNT_W'(1);
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         presc_q    <= '0;
         rem_q      <= '0;
         load_q     <= '0;
         periodic_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         rem_q      <= rem_d;
         load_q     <= load_d;
         periodic_q <= periodic_d;
         timeout_q  <= timeout_d;
      end
   end

   assign tmr_io.busy         = (state_q == StRun);
   assign tmr_io.done         = (state_q == StExpired);
   assign tmr_io.timeout      = timeout_q;
   assign tmr_io.remaining_ms = rem_q;

`ifdef TIMER_WARN_EN
   logic warn_arm_d, warn_arm_q;
   logic warn_d, warn_q;

   // Arm on the decrement that lands on the threshold; pulse one cycle after it is visible.
   always_comb begin
      warn_arm_d = 1'b0;
      warn_d     = warn_arm_q;
      if (ms_tick && (rem_q > CNT_W'(1)) && ((rem_q - CNT_W'(1)) == CNT_W'(WARN_MS))) begin
         warn_arm_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warn_arm_q <= 1'b0;
         warn_q     <= 1'b0;
      end else begin
         warn_arm_q <= warn_arm_d;
         warn_q     <= warn_d;
      end
   end

   assign tmr_io.warn = warn_q;
`else
   assign tmr_io.warn = 1'b0;
`endif
endmodule

// File: tb/tb_programmable_timeout_timer.sv
// Self-checking bench for programmable_timeout_timer: directed scenarios plus random commands,
// every cycle compared against a cycles-to-expiry reference model.
module tb_programmable_timeout_timer;
   localparam int unsigned T    = 4;
   localparam int unsigned CW   = 8;
   localparam int unsigned WARN = 2;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   programmable_timeout_timer_if #(.CNT_W(CW)) tif ();

   programmable_timeout_timer #(
      .TICKS_PER_MS(T),
      .CNT_W       (CW),
      .WARN_MS     (WARN)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tmr_io(tif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model keeps the interval as a plain count of clock cycles left until expiry.
   bit m_run, m_done, m_per, m_to, m_warn, m_warn_pend;
   int m_cyc, m_period;

   function automatic void model_reset();
      m_run = 0; m_done = 0; m_per = 0; m_to = 0; m_warn = 0; m_warn_pend = 0;
      m_cyc = 0; m_period = 0;
   endfunction

   function automatic void model_edge();
      m_warn      = m_warn_pend;
      m_warn_pend = 0;
      m_to        = 0;
      if (tif.abort) begin
         m_run = 0; m_done = 0; m_cyc = 0;
      end else if (tif.start) begin
         m_per    = tif.periodic;
         m_period = int'(tif.load_ms);
         m_done   = 0;
         if (m_period != 0) begin
            m_run = 1;
            m_cyc = m_period * int'(T);
         end else begin
            m_to   = 1;
            m_run  = 0;
            m_done = !tif.periodic;
            m_cyc  = 0;
         end
      end else if (m_run && !tif.pause) begin
         m_cyc = m_cyc - 1;
         if (m_cyc != 0 && m_cyc == int'(WARN * T)) m_warn_pend = 1;
         if (m_cyc == 0) begin
            m_to = 1;
            if (m_per) m_cyc = m_period * int'(T);
            else begin
               m_run  = 0;
               m_done = 1;
            end
         end
      end
   endfunction

   function automatic int exp_rem();
      return m_run ? (m_cyc + int'(T) - 1) / int'(T) : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit s, input bit a, input bit p, input bit per, input int ld);
      tif.start    = s;
      tif.abort    = a;
      tif.pause    = p;
      tif.periodic = per;
      tif.load_ms  = CW'(ld);
   endtask

   // One clock edge: advance model, sample #1 later, compare, return at the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("busy", 32'(tif.busy), 32'(m_run));
      check("done", 32'(tif.done), 32'(m_done));
      check("timeout", 32'(tif.timeout), 32'(m_to));
      check("remaining_ms", 32'(tif.remaining_ms), 32'(exp_rem()));
`ifdef TIMER_WARN_EN
      check("warn", 32'(tif.warn), 32'(m_warn));
`else
      check("warn", 32'(tif.warn), 32'(0));
`endif
      @(negedge clk);
   endtask

   initial begin
      int             n;
      int             nw;
      int             cnt;
      int             q[$];
      logic [CW-1:0]  held;

      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #12;
      check("rst_busy", 32'(tif.busy), 32'(0));
      check("rst_done", 32'(tif.done), 32'(0));
      check("rst_timeout", 32'(tif.timeout), 32'(0));
      check("rst_rem", 32'(tif.remaining_ms), 32'(0));
      check("rst_warn", 32'(tif.warn), 32'(0));
      rst = 1'b1;
      @(negedge clk);

      // One-shot load 3: expiry 12 cycles after the start edge.
      drive(1, 0, 0, 0, 3);
      step();
      drive(0, 0, 0, 0, 0);
      n = -1;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (tif.timeout) begin n = i; break; end
      end
      check("oneshot_latency", 32'(n), 32'(12));
      check("oneshot_done", 32'(tif.done), 32'(1));
      check("oneshot_busy", 32'(tif.busy), 32'(0));
      check("oneshot_rem", 32'(tif.remaining_ms), 32'(0));
      step();
      step();
      drive(1, 0, 0, 0, 2);
      step();
      drive(0, 0, 0, 0, 0);
      check("done_cleared", 32'(tif.done), 32'(0));

      // Async reset mid-run: outputs clear at once, no timeout afterwards.
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      check("arst_busy", 32'(tif.busy), 32'(0));
      check("arst_rem", 32'(tif.remaining_ms), 32'(0));
      check("arst_timeout", 32'(tif.timeout), 32'(0));
      check("arst_done", 32'(tif.done), 32'(0));
      rst = 1'b1;
      model_reset();
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (tif.timeout) cnt++;
      end
      check("arst_no_timeout", 32'(cnt), 32'(0));

      // Periodic load 2: pulse every 8 cycles; abort stops it.
      drive(1, 0, 0, 1, 2);
      step();
      drive(0, 0, 0, 0, 0);
      q.delete();
      for (int i = 1; i <= 40; i++) begin
         step();
         if (tif.timeout) q.push_back(i);
      end
      check("per_pulses", 32'(q.size()), 32'(5));
      if (q.size() > 0) check("per_first", 32'(q[0]), 32'(8));
      for (int k = 1; k < q.size(); k++) check("per_gap", 32'(q[k] - q[k-1]), 32'(8));
      drive(0, 1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (tif.timeout || tif.busy) cnt++;
      end
      check("abort_quiet", 32'(cnt), 32'(0));

      // Pause for 5 cycles mid-interval stretches expiry to 17.
      drive(1, 0, 0, 0, 3);
      step();
      drive(0, 0, 0, 0, 0);
      n = -1;
      held = '0;
      for (int i = 1; i <= 40; i++) begin
         tif.pause = (i >= 3 && i <= 7);
         step();
         if (i == 2) held = tif.remaining_ms;
         if (tif.pause) check("pause_hold", 32'(tif.remaining_ms), 32'(held));
         if (tif.timeout) begin n = i; break; end
      end
      tif.pause = 1'b0;
      check("pause_latency", 32'(n), 32'(17));

      // Restart at cycle 6 with load 1 -> expiry at cycle 10.
      drive(1, 0, 0, 0, 5);
      step();
      drive(0, 0, 0, 0, 0);
      n = -1;
      for (int i = 1; i <= 30; i++) begin
         if (i == 6) drive(1, 0, 0, 0, 1);
         else drive(0, 0, 0, 0, 0);
         step();
         if (tif.timeout) begin n = i; break; end
      end
      drive(0, 0, 0, 0, 0);
      check("restart_latency", 32'(n), 32'(10));

      // Start coincident with expiry: old interval gives no pulse.
      drive(1, 0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0, 0);
      step(); step(); step();
      drive(1, 0, 0, 0, 2);
      step();
      drive(0, 0, 0, 0, 0);
      check("coinc_no_pulse", 32'(tif.timeout), 32'(0));
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (tif.timeout) begin n = i; break; end
      end
      check("coinc_new_latency", 32'(n), 32'(8));

      // Zero interval: immediate pulse.
      drive(1, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check("zero_os_timeout", 32'(tif.timeout), 32'(1));
      check("zero_os_done", 32'(tif.done), 32'(1));
      step();
      check("zero_os_single", 32'(tif.timeout), 32'(0));
      drive(1, 0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check("zero_per_timeout", 32'(tif.timeout), 32'(1));
      check("zero_per_idle", 32'(tif.busy | tif.done), 32'(0));

      // Warn pulse on load 4.
      drive(1, 0, 0, 0, 4);
      step();
      drive(0, 0, 0, 0, 0);
      nw = -1;
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (tif.warn) begin
            cnt++;
            if (nw < 0) nw = i;
         end
      end
`ifdef TIMER_WARN_EN
      check("warn_cycle", 32'(nw), 32'(9));
      check("warn_count", 32'(cnt), 32'(1));
`else
      check("warn_absent", 32'(cnt), 32'(0));
`endif

      // Random command mix against the model.
      for (int i = 0; i < 800; i++) begin
         tif.start    = ($urandom_range(0, 19) == 0);
         tif.abort    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) tif.pause = ~tif.pause;
         tif.periodic = 1'($urandom_range(0, 1));
         tif.load_ms  = CW'($urandom_range(0, 6));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
